sigarch_stream_fifo: RTL



---
 rtl/sigarch_stream_fifo_if.sv | 15 +
 rtl/sigarch_stream_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sigarch_stream_fifo_if.sv
// AXI-stream style beat bus: data, byte keep, end-of-packet, valid/ready handshake.
interface sigarch_stream_fifo_if #(
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              valid;
    logic              ready;

    modport transmitter (output data, keep, last, valid, input  ready);
    modport receiver    (input  data, keep, last, valid, output ready);
endinterface

// File: rtl/sigarch_stream_fifo.sv
// Stream FIFO with first-word-fall-through egress, registered ingress ready and
// optional store-and-forward release (whole packet stored, or buffer full).
module sigarch_stream_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PACKET_MODE = 0,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sigarch_stream_fifo_if.receiver     stream_in,
    sigarch_stream_fifo_if.transmitter  stream_out,
    output logic [$clog2(DEPTH):0]      level,
    output logic [$clog2(DEPTH):0]      pkt_count,
    output logic                        full,
    output logic                        empty
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_FWD  = 1'b1
    } state_e;

    beat_t           mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   level_q, level_d;
    logic [PW-1:0]   pkt_q, pkt_d;
    logic            ready_q, ready_d;
    state_e          state_q;

    beat_t           head_c;
    logic            empty_c, full_c, full_next_c;
    logic            release_c, valid_c;
    logic            wr_fire_c, rd_fire_c;
    logic            pkt_inc_c, pkt_dec_c;

    // Pointer, occupancy and release bookkeeping for the current cycle.
    always_comb begin
        head_c      = mem_q[rd_ptr_q[AW-1:0]];
        empty_c     = (wr_ptr_q == rd_ptr_q);
        full_c      = (wr_ptr_q == (rd_ptr_q ^ PW'(DEPTH)));
        release_c   = (PACKET_MODE == 0) || (state_q == ST_FWD) || (pkt_q != '0) || full_c;
        valid_c     = !empty_c && release_c;
        wr_fire_c   = stream_in.valid && ready_q;
        rd_fire_c   = valid_c && stream_out.ready;
        pkt_inc_c   = wr_fire_c && stream_in.last;
        pkt_dec_c   = rd_fire_c && head_c.last;

        wr_ptr_d    = wr_ptr_q + PW'(wr_fire_c);
        rd_ptr_d    = rd_ptr_q + PW'(rd_fire_c);
        full_next_c = (wr_ptr_d == (rd_ptr_d ^ PW'(DEPTH)));
        ready_d     = !full_next_c;

        level_d = level_q;
        if (wr_fire_c && !rd_fire_c) begin
            level_d = level_q + PW'(1);
        end else if (rd_fire_c && !wr_fire_c) begin
            level_d = level_q - PW'(1);
        end

        pkt_d = pkt_q;
        if (pkt_inc_c && !pkt_dec_c) begin
            pkt_d = pkt_q + PW'(1);
        end else if (pkt_dec_c && !pkt_inc_c) begin
            pkt_d = pkt_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pkt_q    <= pkt_d;
            ready_q  <= ready_d;
        end
    end

    // Release state: FWD once a packet has started leaving, back to HOLD at its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
        end else if (rd_fire_c) begin
            state_q <= head_c.last ? ST_HOLD : ST_FWD;
        end
    end

    // Beat storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{data: stream_in.data,
                                        keep: stream_in.keep,
                                        last: stream_in.last};
        end
    end

    assign stream_in.ready  = ready_q;
    assign stream_out.valid = valid_c;
    assign stream_out.data  = head_c.data;
    assign stream_out.keep  = head_c.keep;
    assign stream_out.last  = head_c.last;
    assign level            = level_q;
    assign pkt_count        = pkt_q;
    assign full             = full_c;
    assign empty            = empty_c;
endmodule
